// File: rtl/phy_ft_pkg.sv
// Shared definitions for the dual-PHY fault-tolerant receive path.
// State encoding, GMII idle value and port indices.
package phy_ft_pkg;

  typedef enum logic [2:0] {
    ST_SYNC  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_FRAME = 3'd2,
    ST_ABORT = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  localparam logic [7:0] GMII_IDLE_DAT = 8'h00;
  localparam logic [7:0] ABORT_DAT     = 8'h00;

  localparam logic PORT_P0 = 1'b0;
  localparam logic PORT_P1 = 1'b1;

endpackage

// File: rtl/sync_bit.sv
// Single-bit level synchronizer into phy0_rxclk.
// STAGES-deep flop chain, cleared by async reset.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic phy0_rxclk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // shift the asynchronous level through the chain
  always_ff @(posedge phy0_rxclk or posedge rst) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/gmii_rx_failover_gate.sv
// Frame-aware PHY0/PHY1 GMII receive selector.
// Switches only between frames, aborts cleanly on link loss or underrun.
module gmii_rx_failover_gate
  import phy_ft_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int IFG_CYCLES  = 12,
  parameter int CNT_W       = 16
) (
  input  logic             phy0_rxclk,
  input  logic             rst,
  input  logic             sel_req,
  input  logic             p0_link,
  input  logic             p1_link,
  input  logic [7:0]       p0_rxdat,
  input  logic             p0_rxdv,
  input  logic             p0_rxer,
  input  logic [7:0]       p1_rxdat,
  input  logic             p1_rxdv,
  input  logic             p1_rxer,
  input  logic             p1_valid,
  output logic [7:0]       rxdat,
  output logic             rxdv,
  output logic             rxer,
  output logic             cur_port,
  output logic             switching,
  output logic [CNT_W-1:0] switch_cnt,
  output logic [CNT_W-1:0] abort_cnt
);

  localparam int GW =
    (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LOAD =
    GW'(IFG_CYCLES - 1);

  state_t        state;
  logic [GW-1:0] gap_cnt;

  logic          tgt;
  logic          lnk0;
  logic          lnk1;

  logic          lnk;
  logic          beat;
  logic          sv_raw;
  logic          sv;
  logic          se;
  logic [7:0]    sd;
  logic          underrun;
  logic          want_sw;

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_sel (
    .phy0_rxclk (phy0_rxclk),
    .rst        (rst),
    .d          (sel_req),
    .q          (tgt)
  );

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_l0 (
    .phy0_rxclk (phy0_rxclk),
    .rst        (rst),
    .d          (p0_link),
    .q          (lnk0)
  );

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_l1 (
    .phy0_rxclk (phy0_rxclk),
    .rst        (rst),
    .d          (p1_link),
    .q          (lnk1)
  );

  // pick the stream of the port currently forwarded
  always_comb begin
    sd     = p0_rxdat;
    sv_raw = p0_rxdv;
    se     = p0_rxer;
    beat   = 1'b1;
    lnk    = lnk0;
    if (cur_port == PORT_P1) begin
      sd     = p1_rxdat;
      sv_raw = p1_rxdv;
      se     = p1_rxer;
      beat   = p1_valid;
      lnk    = lnk1;
    end
  end

  // a PHY1 beat only exists when the elastic buffer presents one
  assign sv       = beat & sv_raw;
  assign underrun = (cur_port == PORT_P1) & ~p1_valid;
  assign want_sw  = (tgt != cur_port);

  // frame FSM with gap timer, output register and event counters
  always_ff @(posedge phy0_rxclk or posedge rst) begin
    if (rst) begin
      state      <= ST_SYNC;
      gap_cnt    <= '0;
      rxdat      <= GMII_IDLE_DAT;
      rxdv       <= 1'b0;
      rxer       <= 1'b0;
      cur_port   <= PORT_P0;
      switching  <= 1'b0;
      switch_cnt <= '0;
      abort_cnt  <= '0;
    end else begin
      switching <= (state == ST_ABORT) ||
                   (state == ST_GAP) ||
                   (state == ST_SYNC);
      rxdat <= GMII_IDLE_DAT;
      rxdv  <= 1'b0;
      rxer  <= 1'b0;
      unique case (state)
        ST_SYNC: begin
          if (beat && !sv_raw) begin
            state <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (want_sw) begin
            state   <= ST_GAP;
            gap_cnt <= GAP_LOAD;
          end else if (sv) begin
            state <= ST_FRAME;
            rxdat <= sd;
            rxdv  <= 1'b1;
            rxer  <= se;
          end
        end
        ST_FRAME: begin
          if (!lnk || underrun) begin
            state <= ST_ABORT;
            rxdat <= ABORT_DAT;
            rxdv  <= 1'b1;
            rxer  <= 1'b1;
            if (~&abort_cnt) begin
              abort_cnt <= abort_cnt + 1'b1;
            end
          end else if (sv) begin
            rxdat <= sd;
            rxdv  <= 1'b1;
            rxer  <= se;
          end else if (want_sw) begin
            state   <= ST_GAP;
            gap_cnt <= GAP_LOAD;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_ABORT: begin
          state   <= ST_GAP;
          gap_cnt <= GAP_LOAD;
        end
        ST_GAP: begin
          if (gap_cnt == '0) begin
            state    <= ST_SYNC;
            cur_port <= tgt;
            if (want_sw && (~&switch_cnt)) begin
              switch_cnt <= switch_cnt + 1'b1;
            end
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: begin
          state <= ST_SYNC;
        end
      endcase
    end
  end

endmodule
